// File: rtl/cond_unit.sv
// Condition evaluation and NZCV flag register stage, one registered cycle with stall.
// Optional event counters exec_count/skip_count are enabled by defining COND_STATS_EN.
module cond_unit #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        stall,
  input  logic [3:0]  cond,
  input  logic [3:0]  alu_flags,
  input  logic [1:0]  flag_w,
  input  logic        pcs,
  input  logic        reg_w,
  input  logic        mem_w,
  input  logic        no_write,
  output logic        valid_out,
  output logic        cond_ex,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_write,
`ifdef COND_STATS_EN
  output logic [15:0] exec_count,
  output logic [15:0] skip_count,
`endif
  output logic [3:0]  flags
);

  logic n, z, c, v;
  logic ce;
  logic accept;

  assign {n, z, c, v} = flags;
  assign accept       = valid_in & ~stall;

  always_comb begin
    ce = 1'b0;
    unique case (cond)
      4'b0000: ce = z;
      4'b0001: ce = ~z;
      4'b0010: ce = c;
      4'b0011: ce = ~c;
      4'b0100: ce = n;
      4'b0101: ce = ~n;
      4'b0110: ce = v;
      4'b0111: ce = ~v;
      4'b1000: ce = c & ~z;
      4'b1001: ce = ~c | z;
      4'b1010: ce = (n == v);
      4'b1011: ce = (n != v);
      4'b1100: ce = ~z & (n == v);
      4'b1101: ce = z | (n != v);
      default: ce = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      cond_ex   <= 1'b0;
      pc_src    <= 1'b0;
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      flags     <= FLAG_RESET;
    end else if (!stall) begin
      valid_out <= valid_in;
      cond_ex   <= valid_in & ce;
      pc_src    <= valid_in & ce & pcs;
      reg_write <= valid_in & ce & reg_w & ~no_write;
      mem_write <= valid_in & ce & mem_w;
      if (valid_in && ce) begin
        if (flag_w[1]) flags[3:2] <= alu_flags[3:2];
        if (flag_w[0]) flags[1:0] <= alu_flags[1:0];
      end
    end
  end

`ifdef COND_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_count <= 16'h0000;
      skip_count <= 16'h0000;
    end else if (accept) begin
      if (ce) exec_count <= exec_count + 16'h0001;
      else    skip_count <= skip_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed and random checks of cond_unit against a scoreboard fed by a reference model.
module tb_cond_unit;

  logic        clk = 1'b0;
  logic        reset, valid_in, stall, pcs, reg_w, mem_w, no_write;
  logic [3:0]  cond, alu_flags;
  logic [1:0]  flag_w;
  logic        valid_out, cond_ex, pc_src, reg_write, mem_write;
  logic [3:0]  flags;
  logic [15:0] exec_count, skip_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cond_unit #(.FLAG_RESET(4'b0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .stall     (stall),
    .cond      (cond),
    .alu_flags (alu_flags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .no_write  (no_write),
    .valid_out (valid_out),
    .cond_ex   (cond_ex),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .mem_write (mem_write),
`ifdef COND_STATS_EN
    .exec_count(exec_count),
    .skip_count(skip_count),
`endif
    .flags     (flags)
  );

`ifndef COND_STATS_EN
  assign exec_count = 16'h0000;
  assign skip_count = 16'h0000;
`endif

  typedef struct packed {
    logic        v, ce, pc, rw, mw;
    logic [3:0]  fl;
    logic [15:0] ec, sc;
  } exp_t;

  exp_t sb[$];
  exp_t last_e = '0;
  logic [3:0]  m_flags = 4'b0000;
  logic [15:0] m_ec = 16'h0, m_sc = 16'h0;

  // Reference uses the base-condition / invert-on-bit0 formulation.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic nn, zz, cc, vv, b;
    {nn, zz, cc, vv} = f;
    case (c[3:1])
      3'd0: b = zz;
      3'd1: b = cc;
      3'd2: b = nn;
      3'd3: b = vv;
      3'd4: b = cc & ~zz;
      3'd5: b = (nn == vv);
      3'd6: b = ~zz & (nn == vv);
      default: b = 1'b1;
    endcase
    if (c[0] && c[3:1] != 3'd7) b = ~b;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic rs, input logic st, input logic vi, input logic [3:0] c,
                      input logic [3:0] a, input logic [1:0] fw, input logic p,
                      input logic r, input logic m, input logic nw);
    exp_t e, g;
    logic ce;
    reset = rs; stall = st; valid_in = vi; cond = c; alu_flags = a; flag_w = fw;
    pcs = p; reg_w = r; mem_w = m; no_write = nw;
    if (rs) begin
      e = '0;
      m_flags = 4'b0000; m_ec = 16'h0; m_sc = 16'h0;
    end else if (st) begin
      e = last_e;
    end else begin
      ce = model_cond(c, m_flags);
      if (vi) begin
        if (ce) m_ec = m_ec + 16'h1;
        else    m_sc = m_sc + 16'h1;
      end
      if (vi && ce) begin
        if (fw[1]) m_flags[3:2] = a[3:2];
        if (fw[0]) m_flags[1:0] = a[1:0];
      end
      e.v = vi; e.ce = vi & ce; e.pc = vi & ce & p;
      e.rw = vi & ce & r & ~nw; e.mw = vi & ce & m;
      e.fl = m_flags; e.ec = m_ec; e.sc = m_sc;
    end
`ifndef COND_STATS_EN
    e.ec = 16'h0; e.sc = 16'h0;
`endif
    last_e = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("valid_out", {15'b0, valid_out}, {15'b0, g.v});
    chk("cond_ex",   {15'b0, cond_ex},   {15'b0, g.ce});
    chk("pc_src",    {15'b0, pc_src},    {15'b0, g.pc});
    chk("reg_write", {15'b0, reg_write}, {15'b0, g.rw});
    chk("mem_write", {15'b0, mem_write}, {15'b0, g.mw});
    chk("flags",     {12'b0, flags},     {12'b0, g.fl});
    chk("exec_count", exec_count, g.ec);
    chk("skip_count", skip_count, g.sc);
  endtask

  localparam logic [3:0] AL = 4'b1110, EQ = 4'b0000, LT = 4'b1011, GE = 4'b1010;

  initial begin
    #1;
    //   rs st vi cond alu      fw     p  r  m  nw
    step(1, 0, 0, EQ, 4'b0000, 2'b00, 0, 0, 0, 0);
    step(1, 0, 1, AL, 4'b1111, 2'b11, 1, 1, 1, 0);
    step(0, 0, 1, EQ, 4'b0000, 2'b00, 0, 1, 0, 0);  // Z=0 so EQ fails
    step(0, 0, 1, AL, 4'b0100, 2'b11, 0, 0, 0, 0);  // set Z
    step(0, 0, 1, EQ, 4'b0000, 2'b00, 0, 1, 0, 0);  // sees Z with no bubble
    step(0, 0, 1, AL, 4'b1000, 2'b11, 1, 0, 1, 0);  // N=1 V=0
    step(0, 0, 1, LT, 4'b0000, 2'b00, 1, 1, 1, 0);
    step(0, 0, 1, GE, 4'b0110, 2'b11, 1, 1, 1, 0);  // fails, flags stay 1000
    step(0, 0, 0, AL, 4'b0110, 2'b11, 1, 1, 1, 0);  // bubble
    step(0, 0, 1, AL, 4'b0000, 2'b11, 0, 0, 0, 0);
    step(0, 0, 1, AL, 4'b1111, 2'b10, 0, 0, 0, 0);  // only N,Z written
    step(0, 0, 1, AL, 4'b0000, 2'b00, 0, 1, 0, 1);  // no_write suppresses reg_write
    step(0, 0, 1, AL, 4'b0011, 2'b01, 1, 1, 1, 0);
    step(0, 1, 1, AL, 4'b0000, 2'b11, 0, 0, 0, 0);
    step(0, 1, 0, EQ, 4'b1010, 2'b11, 1, 1, 1, 0);
    step(0, 1, 1, GE, 4'b0101, 2'b01, 0, 1, 0, 0);
    step(1, 1, 1, AL, 4'b1111, 2'b11, 1, 1, 1, 0);  // reset overrides stall
    // Counter phase: 5 pass, 3 fail, 2 stalled
    for (int i = 0; i < 5; i++) step(0, 0, 1, AL, 4'b0000, 2'b00, 0, 1, 0, 0);
    step(0, 1, 1, AL, 4'b0000, 2'b00, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, EQ, 4'b0000, 2'b00, 0, 1, 0, 0);
    step(0, 1, 1, EQ, 4'b0000, 2'b00, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0), 1'($urandom),
           4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    end
`ifdef COND_STATS_EN
    step(1, 0, 0, EQ, 4'b0000, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) step(0, 0, 1, AL, 4'b0000, 2'b00, 0, 0, 0, 0);
    step(0, 0, 1, AL, 4'b0000, 2'b00, 0, 0, 0, 0);  // FFFF wraps to 0
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Condition-evaluation and flag-register stage that consumes the four status flags produced by the team's ALU (`negative`, `zero`, `carry`, `overflow`). It holds the architectural NZCV flags and evaluates a 4-bit ARM-style condition code against them. It gates the instruction's register, memory and PC writes, and updates the flags from the ALU on executed flag-setting instructions. It sits between decode/ALU and writeback as a one-cycle registered pipeline stage with stall.

## Interface
- FLAG_RESET, 4'b0000, reset value of the flag register {N,Z,C,V}
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- valid_in  input  1  instruction present this cycle
- stall  input  1  hold all state; inputs ignored
- cond  input  4  condition code of the instruction
- alu_flags  input  4  {negative, zero, carry, overflow} from the ALU for this instruction
- flag_w  input  2  [1] writes N,Z; [0] writes C,V
- pcs  input  1  instruction writes PC
- reg_w  input  1  instruction writes register file
- mem_w  input  1  instruction writes memory
- no_write  input  1  compare-type op; suppresses reg_w
- valid_out  output  1  registered valid
- cond_ex  output  1  registered condition result
- pc_src  output  1  registered pcs & cond_ex
- reg_write  output  1  registered reg_w & ~no_write & cond_ex
- mem_write  output  1  registered mem_w & cond_ex
- flags  output  4  current flag register {N,Z,C,V}
- exec_count, skip_count  output  16 each  present only with COND_STATS_EN

## Operation
- Condition is evaluated combinationally against the flag register value at the start of the cycle, before this instruction's own flag update.
- Codes: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 1 (treated as AL).
- Flag update on edge when valid_in & ~stall & ce: flags[3:2] <= alu_flags[3:2] if flag_w[1]; flags[1:0] <= alu_flags[1:0] if flag_w[0]. ce is the combinational condition result.
- Failed condition: no flag update; pc_src/reg_write/mem_write are 0, and valid_out is still 1.
- valid_in=0: on the next edge valid_out=0, cond_ex=0, all write outputs 0, and flags are unchanged.
- C is stored exactly as the ALU supplies it; no inversion.

## Timing
- Latency 1 cycle: outputs reflect the instruction presented on the preceding accepted edge.
- A flag update is visible on `flags`, and to the condition of the next instruction, in the cycle after the edge. Back-to-back flag-setting then conditional instructions need no bubble.
- stall=1: all registers, flags and counters hold, and valid_in is ignored.
- reset=1 on an edge: valid_out, cond_ex, pc_src, reg_write and mem_write are 0; flags=FLAG_RESET; counters are 0. Reset overrides stall and valid_in, including mid-stream. The first instruction is accepted on the first edge with reset=0.

## Configuration
- COND_STATS_EN defined: adds exec_count and skip_count. On each accepted edge (valid_in & ~stall), exec_count increments if ce, else skip_count increments. Both wrap from 16'hFFFF to 0 and reset to 0.
- Undefined: the ports and counters do not exist, and all other behaviour is identical.

## Test plan
- After reset, cond=0000, valid_in=1, reg_w=1 -> next cycle valid_out=1, cond_ex=0 (Z=0), reg_write=0, flags=0000.
- alu_flags=0100, flag_w=11, cond=1110 (AL), then cond=0000 with reg_w=1 on the next cycle -> flags=0100 after the first edge; the second instruction has cond_ex=1, reg_write=1.
- flags=1000 (N=1,V=0): cond=1011 (LT) -> cond_ex=1; cond=1010 (GE) -> cond_ex=0. The failing instruction with flag_w=11, alu_flags=0110 leaves flags=1000.
- flag_w=10 with alu_flags=1111 from flags=0000 -> flags=1100. no_write=1, reg_w=1, cond=AL -> reg_write=0, cond_ex=1.
- Assert stall for 3 cycles with varying inputs -> outputs and flags hold. Assert reset while stall=1 -> all outputs 0 and flags=FLAG_RESET on the next cycle.
- COND_STATS_EN: 5 passing and 3 failing accepted instructions plus 2 stalled cycles -> exec_count=5, skip_count=3. Preloading exec_count to FFFF and executing one more -> 0000.
